decode_issue_ctrl: RTL and testbench
====================================

# decode_issue_ctrl

Issue controller between instruction fetch and execute. Holds one decoded-stage instruction in an output register, tracks outstanding register writes in a 32-entry scoreboard, and stalls fetch on RAW/WAW hazards until writeback clears them. Also applies pipeline flush on branch redirect and counts hazard-stall cycles for performance monitoring.

## Interface
- XLEN, default from rapid_pkg (32); instruction width.
- STALL_CNT_W, default 16; width of the saturating stall counter.

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_valid  in  1  fetch presents i_instruction
- o_ready  out  1  controller accepts i_instruction this cycle
- i_instruction  in  XLEN  raw RV32I instruction
- o_valid  out  1  o_instruction valid for execute
- i_ready  in  1  execute accepts o_instruction
- o_instruction  out  XLEN  registered instruction
- i_flush  in  1  branch redirect; kill held instruction
- i_wb_valid  in  1  writeback retires a register write
- i_wb_rd  in  5  destination register being retired
- o_pending  out  32  scoreboard bitmap; bit n = write to xn outstanding
- o_stall_cnt  out  STALL_CNT_W  hazard-stall cycle count

## Operation
- Opcode class from instr[6:2], valid only if instr[1:0]==2'b11:
  - 01101 LUI, 00101 AUIPC, 11011 JAL: no rs; writes rd.
  - 11001 JALR, 00000 load, 00100 ALU-imm: rs1; writes rd.
  - 11000 branch, 01000 store: rs1+rs2; no rd write.
  - 01100 ALU-reg: rs1+rs2; writes rd.
  - Anything else: no rs, no rd write; passes through unchanged.
- rs1=[19:15], rs2=[24:20], rd=[11:7]. Register x0 is never hazardous and never set pending.
- Hazard on input instruction (rd' = rd of held instruction, writes' = its rd-write flag):
  - Any used rs, or rd if the input writes rd, has its o_pending bit set; or
  - o_valid && writes' && rd'!=0 && rd' equals any used rs or the written rd (conservative even when the held instruction issues this cycle).
- o_ready = !i_flush && !hazard && (!o_valid || (i_ready && !i_flush)).
- Issue: o_valid && i_ready && !i_flush. Sets o_pending[rd'] if writes' and rd'!=0.
- Writeback: i_wb_valid clears o_pending[i_wb_rd] (x0 ignored). A set and a clear to the same bit in the same cycle: set wins.
- Flush: next cycle o_valid=0; held instruction is discarded and not issued even if i_ready=1; scoreboard untouched, since older in-flight writes still retire.
- o_stall_cnt increments when i_valid && hazard && !i_flush; saturates at all-ones.

## Timing
- Reset values: o_valid=0, o_instruction=0, o_pending=0, o_stall_cnt=0. o_ready is combinational and 0 while i_rst is high.
- Latency: accepted instruction appears at o_valid the following cycle. Full throughput (one per cycle) when hazard-free and i_ready=1.
- Execute stall (o_valid && !i_ready): o_instruction and o_valid hold stable.
- Scoreboard set or clear becomes visible in o_pending and the hazard check the cycle after the event (unless the configuration macro below is defined).
- Reset asserted mid-operation clears all state immediately. Writebacks arriving after reset for pre-reset instructions are legal and clear bits that are already 0.

## Configuration
- DECODE_WB_BYPASS_EN defined: the hazard check uses o_pending with the same-cycle i_wb_rd bit masked off, so a dependent instruction is accepted in the same cycle as its producer's writeback. The mask is skipped if an issue sets the same bit in that cycle. o_pending output itself remains registered.
- Undefined: no bypass; a dependent instruction is accepted at the earliest one cycle after writeback.

## Test plan
- Back-to-back independent ADDI x1/x2/x3 with i_ready=1: three accepts in consecutive cycles, o_pending=0x0000000E after the third issue, o_stall_cnt=0.
- ADD x5,x1,x2 issued, then SUB x6,x5,x3 presented: o_ready=0 until writeback of rd=5; stall count equals the stalled cycles. Without DECODE_WB_BYPASS_EN, accept occurs the cycle after writeback; with it, in the same cycle.
- SW x5,0(x1) with x5 pending: stalled. BEQ x0,x0: never stalls and sets no bit.
- Held LW x7 with i_ready=1 and i_flush=1 in the same cycle: not issued, o_valid=0 next cycle, o_pending[7]=0.
- Issue of a writer to x4 coinciding with i_wb_rd=4: o_pending[4]=1 afterwards.
- Assert i_rst mid-stream with pending bits set and o_valid=1: all outputs reset immediately. Counter saturation checked with STALL_CNT_W=4: holds at 15 after more than 15 stall cycles.

Source files
------------

// File: rtl/decode_issue_ctrl_if.sv
// decode_issue_ctrl_if: fetch-side, execute-side and writeback signals of the
// decode/issue controller, bundled as one port.
// Modport slave is the controller's view. Modport master is the view of the
// surrounding pipeline (fetch, execute and writeback).
interface decode_issue_ctrl_if #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
);
  logic                   i_valid;
  logic                   o_ready;
  logic [XLEN-1:0]        i_instruction;
  logic                   o_valid;
  logic                   i_ready;
  logic [XLEN-1:0]        o_instruction;
  logic                   i_flush;
  logic                   i_wb_valid;
  logic [4:0]             i_wb_rd;
  logic [31:0]            o_pending;
  logic [STALL_CNT_W-1:0] o_stall_cnt;

  modport slave (
    input  i_valid, i_instruction, i_ready, i_flush, i_wb_valid, i_wb_rd,
    output o_ready, o_valid, o_instruction, o_pending, o_stall_cnt
  );

  modport master (
    output i_valid, i_instruction, i_ready, i_flush, i_wb_valid, i_wb_rd,
    input  o_ready, o_valid, o_instruction, o_pending, o_stall_cnt
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: holds one decoded instruction between fetch and execute.
// A 32-entry scoreboard tracks outstanding register writes. Fetch is stalled
// on RAW/WAW hazards until writeback clears them. A branch flush kills the
// held instruction. Hazard-stall cycles are counted with a saturating counter.
// Optional feature macro: DECODE_WB_BYPASS_EN. When it is defined, a
// writeback in the current cycle unblocks a dependent instruction in that
// same cycle.
module decode_issue_ctrl #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  decode_issue_ctrl_if.slave bus
);

  // Operand usage class derived from the RV32I major opcode.
  typedef enum logic [2:0] {
    CLS_NONE,   // no sources, no destination (also any non-32-bit encoding)
    CLS_U,      // LUI / AUIPC / JAL: destination only
    CLS_I,      // JALR / load / ALU-imm: rs1 and destination
    CLS_S,      // branch / store: rs1 and rs2, no destination
    CLS_R       // ALU-reg: rs1, rs2 and destination
  } op_cls_e;

  function automatic op_cls_e classify(input logic [XLEN-1:0] ins);
    op_cls_e c;
    c = CLS_NONE;
    if (ins[1:0] == 2'b11) begin
      unique case (ins[6:2])
        5'b01101, 5'b00101, 5'b11011: c = CLS_U;
        5'b11001, 5'b00000, 5'b00100: c = CLS_I;
        5'b11000, 5'b01000:           c = CLS_S;
        5'b01100:                     c = CLS_R;
        default:                      c = CLS_NONE;
      endcase
    end
    return c;
  endfunction

  logic                   valid_q;
  logic [XLEN-1:0]        instr_q;
  logic [31:0]            pending_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  op_cls_e     in_cls;
  op_cls_e     held_cls;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [4:0]  held_rd;
  logic        in_use_rs1;
  logic        in_use_rs2;
  logic        in_writes;
  logic        held_writes;
  logic        issue;
  logic        accept;
  logic        hazard;
  logic        ready;
  logic [31:0] issue_set;
  logic [31:0] wb_clr;
  logic [31:0] pend_view;

  // x0 is excluded up front, so it can never cause a hazard or be marked pending.
  assign in_cls      = classify(bus.i_instruction);
  assign held_cls    = classify(instr_q);
  assign in_rs1      = bus.i_instruction[19:15];
  assign in_rs2      = bus.i_instruction[24:20];
  assign in_rd       = bus.i_instruction[11:7];
  assign held_rd     = instr_q[11:7];
  assign in_use_rs1  = (in_cls inside {CLS_I, CLS_S, CLS_R}) && (in_rs1 != 5'd0);
  assign in_use_rs2  = (in_cls inside {CLS_S, CLS_R}) && (in_rs2 != 5'd0);
  assign in_writes   = (in_cls inside {CLS_U, CLS_I, CLS_R}) && (in_rd != 5'd0);
  assign held_writes = (held_cls inside {CLS_U, CLS_I, CLS_R}) && (held_rd != 5'd0);

  assign issue     = valid_q && bus.i_ready && !bus.i_flush;
  assign issue_set = (issue && held_writes) ? (32'd1 << held_rd) : 32'd0;
  assign wb_clr    = (bus.i_wb_valid && bus.i_wb_rd != 5'd0) ? (32'd1 << bus.i_wb_rd) : 32'd0;

`ifdef DECODE_WB_BYPASS_EN
  // A retiring write unblocks dependents now, unless the held instruction
  // re-marks that same register in this cycle.
  assign pend_view = pending_q & ~(wb_clr & ~issue_set);
`else
  assign pend_view = pending_q;
`endif

  // Hazard check: scoreboard hits on used operands, plus a conservative
  // match against the destination of the instruction currently held.
  always_comb begin
    // NOTE: default first so every path assigns hazard and no latch is inferred.
    hazard = 1'b0;
    if (in_use_rs1 && pend_view[in_rs1]) hazard = 1'b1;
    if (in_use_rs2 && pend_view[in_rs2]) hazard = 1'b1;
    if (in_writes  && pend_view[in_rd])  hazard = 1'b1;
    if (valid_q && held_writes) begin
      if ((in_use_rs1 && in_rs1 == held_rd) ||
          (in_use_rs2 && in_rs2 == held_rd) ||
          (in_writes  && in_rd  == held_rd)) begin
        hazard = 1'b1;
      end
    end
  end

  assign ready  = !i_rst && !bus.i_flush && !hazard && (!valid_q || bus.i_ready);
  assign accept = bus.i_valid && ready;

  // Output register, scoreboard and stall counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    if (i_rst) begin
      valid_q     <= 1'b0;
      instr_q     <= '0;
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.i_flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        instr_q <= bus.i_instruction;
      end else if (issue) begin
        valid_q <= 1'b0;
      end
      // Clear is applied before set, so a set wins on a collision.
      pending_q <= (pending_q & ~wb_clr) | issue_set;
      if (bus.i_valid && hazard && !bus.i_flush && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_valid       = valid_q;
  assign bus.o_instruction = instr_q;
  assign bus.o_pending     = pending_q;
  assign bus.o_stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: scoreboard bench for decode_issue_ctrl.
// The driver runs a register-level reference model and queues the expected
// outputs. A negedge monitor pops the queues and compares against the DUT.
// The counter is built 4 bits wide so that saturation is reachable.
module tb_decode_issue_ctrl;
  localparam int XLEN = 32;
  localparam int CW   = 4;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [4:0] OP_LUI = 5'b01101, OP_AUIPC = 5'b00101, OP_JAL = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001, OP_LOAD = 5'b00000, OP_IMM = 5'b00100;
  localparam logic [4:0] OP_BRANCH = 5'b11000, OP_STORE = 5'b01000, OP_ALU = 5'b01100;
  localparam logic [4:0] OP_FENCE = 5'b00011, OP_SYSTEM = 5'b11100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.XLEN(XLEN), .STALL_CNT_W(CW)) bus ();
  decode_issue_ctrl #(.XLEN(XLEN), .STALL_CNT_W(CW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic          rdy;
    logic          vld;
    logic [31:0]   ins;
    logic [31:0]   pend;
    logic [CW-1:0] cnt;
  } status_t;

  // Registers an instruction touches. -1 means not used; x0 is folded into -1.
  typedef struct packed {
    int s1;
    int s2;
    int d;
  } regs_t;

  status_t     st_q[$];
  logic [31:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          pushed   = 0;
  int          popped   = 0;

  // Reference model state.
  bit          m_valid;
  logic [31:0] m_instr;
  bit          m_pend[32];
  int          m_cnt;
  bit          last_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] opc, input int rd, input int rs1, input int rs2);
    logic [4:0] a, b, c;
    a = 5'(rd);
    b = 5'(rs1);
    c = 5'(rs2);
    return {7'd0, c, b, 3'd0, a, opc, 2'b11};
  endfunction

  function automatic int nz(input logic [4:0] r);
    return (r == 5'd0) ? -1 : int'(r);
  endfunction

  function automatic regs_t regs_of(input logic [31:0] ins);
    regs_t r;
    r = '{s1: -1, s2: -1, d: -1};
    if (ins[1:0] == 2'b11) begin
      case (ins[6:2])
        OP_LUI, OP_AUIPC, OP_JAL: r.d = nz(ins[11:7]);
        OP_JALR, OP_LOAD, OP_IMM: begin r.s1 = nz(ins[19:15]); r.d = nz(ins[11:7]); end
        OP_BRANCH, OP_STORE:      begin r.s1 = nz(ins[19:15]); r.s2 = nz(ins[24:20]); end
        OP_ALU: begin r.s1 = nz(ins[19:15]); r.s2 = nz(ins[24:20]); r.d = nz(ins[11:7]); end
        default: ;
      endcase
    end
    return r;
  endfunction

  // A register blocks if it is pending, unless a writeback this very cycle
  // retires it (bypass build only) and no issue re-marks it this cycle.
  function automatic bit blocked(input int x, input bit wbv, input logic [4:0] wbr, input int iset);
    if (!m_pend[x]) return 1'b0;
    if (BYPASS && wbv && int'(wbr) == x && iset != x) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock of stimulus: drive the inputs, predict the DUT, queue the
  // expectations, advance the model and move to the next cycle.
  task automatic step(input bit v, input logic [31:0] ins, input bit rdy, input bit fl,
                      input bit wbv, input logic [4:0] wbr, input bit r);
    regs_t   in_r, held_r;
    bit      hz, rdy_m, iss, acc;
    int      iset;
    int      ops[3];
    status_t s;
    rst               = r;
    bus.i_valid       = v;
    bus.i_instruction = ins;
    bus.i_ready       = rdy;
    bus.i_flush       = fl;
    bus.i_wb_valid    = wbv;
    bus.i_wb_rd       = wbr;
    if (r) begin
      m_valid = 1'b0;
      m_instr = '0;
      m_cnt   = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end
    in_r   = regs_of(ins);
    held_r = regs_of(m_instr);
    iss    = !r && m_valid && rdy && !fl;
    iset   = iss ? held_r.d : -1;
    ops    = '{in_r.s1, in_r.s2, in_r.d};
    hz     = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (ops[k] >= 0) begin
        if (blocked(ops[k], wbv, wbr, iset)) hz = 1'b1;
        if (m_valid && held_r.d == ops[k]) hz = 1'b1;
      end
    end
    rdy_m = !r && !fl && !hz && (!m_valid || rdy);
    acc   = v && rdy_m;
    s.rdy  = rdy_m;
    s.vld  = m_valid;
    s.ins  = m_instr;
    s.pend = pend_vec();
    s.cnt  = CW'(m_cnt);
    st_q.push_back(s);
    pushed++;
    if (iss) exp_q.push_back(m_instr);
    if (!r) begin
      if (v && hz && !fl && m_cnt < (2 ** CW) - 1) m_cnt++;
      if (wbv && wbr != 5'd0) m_pend[wbr] = 1'b0;
      if (iset >= 0) m_pend[iset] = 1'b1;
      if (fl) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_instr = ins;
      end else if (iss) m_valid = 1'b0;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy, input bit wbv, input logic [4:0] wbr);
    step(1'b0, 32'd0, rdy, 1'b0, wbv, wbr, 1'b0);
  endtask

  // Monitor: compare the status every cycle, and score issued instructions.
  always @(negedge clk) begin
    status_t e;
    logic [31:0] x;
    if (st_q.size() != 0) begin
      e = st_q.pop_front();
      popped++;
      check("o_ready", 64'(bus.o_ready), 64'(e.rdy));
      check("o_valid", 64'(bus.o_valid), 64'(e.vld));
      check("o_instruction", 64'(bus.o_instruction), 64'(e.ins));
      check("o_pending", 64'(bus.o_pending), 64'(e.pend));
      check("o_stall_cnt", 64'(bus.o_stall_cnt), 64'(e.cnt));
      if (bus.o_valid && bus.i_ready && !bus.i_flush && !rst) begin
        check("issue_count", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("issued_instruction", 64'(bus.o_instruction), 64'(x));
        end
      end
      if (exp_q.size() != 0) begin
        check("issue_missing", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end
    end
  end

  initial begin
    logic [4:0] opcs[10];
    logic [31:0] ins;
    opcs = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM,
             OP_BRANCH, OP_STORE, OP_ALU, OP_SYSTEM};
    bus.i_valid = 1'b0; bus.i_instruction = '0; bus.i_ready = 1'b0;
    bus.i_flush = 1'b0; bus.i_wb_valid = 1'b0; bus.i_wb_rd = '0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back independent ADDI x1/x2/x3; pending becomes 0x0000000E.
    for (int i = 1; i <= 3; i++) step(1, enc(OP_IMM, i, 0, 0), 1, 0, 0, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);
    for (int i = 1; i <= 3; i++) idle(1, 1, 5'(i));

    // ADD x5,x1,x2 then dependent SUB x6,x5,x3; writeback of x5 releases it.
    step(1, enc(OP_ALU, 5, 1, 2), 1, 0, 0, 0, 0);
    last_acc = 0;
    for (int k = 0; k < 12 && !last_acc; k++)
      step(1, enc(OP_ALU, 6, 5, 3), 1, 0, k == 5, 5'd5, 0);
    idle(1, 0, 0);
    idle(1, 1, 5'd6);

    // SW x5 with x5 pending stalls; BEQ x0,x0 never does.
    step(1, enc(OP_ALU, 5, 1, 2), 1, 0, 0, 0, 0);
    idle(1, 0, 0);
    for (int k = 0; k < 3; k++) step(1, enc(OP_STORE, 0, 1, 5), 1, 0, 0, 0, 0);
    step(1, enc(OP_BRANCH, 0, 0, 0), 1, 0, 0, 0, 0);
    idle(1, 0, 0);
    idle(1, 1, 5'd5);

    // Held LW x7 flushed while execute is ready: never issued, x7 stays clear.
    step(1, enc(OP_LOAD, 7, 1, 0), 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);

    // Issue of a writer to x4 collides with writeback of x4: set wins.
    step(1, enc(OP_IMM, 4, 0, 0), 0, 0, 0, 0, 0);
    idle(1, 1, 5'd4);
    idle(1, 0, 0);

    // Counter saturation: more than 15 stall cycles with no writeback.
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, enc(OP_ALU, 5, 1, 2), 1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(1, enc(OP_ALU, 6, 5, 3), 1, 0, 0, 0, 0);

    // Reset mid-stream with pending bits set and an instruction held.
    step(1, enc(OP_IMM, 8, 0, 0), 1, 0, 0, 0, 0);
    step(1, enc(OP_IMM, 9, 0, 0), 0, 0, 0, 0, 0);
    step(1, enc(OP_IMM, 10, 0, 0), 0, 0, 0, 0, 1);
    idle(1, 1, 5'd8);
    idle(1, 0, 0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      ins = enc(opcs[$urandom_range(0, 9)], $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ins[1:0] = 2'(($urandom_range(0, 2)));
      step($urandom_range(0, 9) < 7, ins, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3,
           5'($urandom_range(0, 7)), $urandom_range(0, 299) == 0);
    end
    idle(1, 0, 0);

    check("status_drained", 64'(popped), 64'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
